melody_buzzer: RTL and testbench

Programmable melody player driving the piezo buzzer pin. It plays a sequence of up to SEQ_LEN notes stored in an internal note table. Note and rest lengths are set in milliseconds, and playback runs either one-shot or looped. A start/stop/busy/done handshake lets the top-level controller trigger it from button or mode logic, in place of the fixed eight-note scale generator.

---
 rtl/melody_buzzer_pkg.sv | 39 +++
 rtl/melody_tone_gen.sv | 29 ++
 rtl/melody_buzzer.sv | 149 ++++++++++++++
 tb/tb_melody_buzzer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/melody_buzzer_pkg.sv
// Shared definitions for the melody buzzer: note codes, tone frequencies, FSM states.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package melody_buzzer_pkg;

    localparam int HALF_W = 27;

    localparam logic [3:0] NOTE_MUTE  = 4'd0;
    localparam logic [3:0] NOTE_DO    = 4'd1;
    localparam logic [3:0] NOTE_RE    = 4'd2;
    localparam logic [3:0] NOTE_MI    = 4'd3;
    localparam logic [3:0] NOTE_FA    = 4'd4;
    localparam logic [3:0] NOTE_SOL   = 4'd5;
    localparam logic [3:0] NOTE_LA    = 4'd6;
    localparam logic [3:0] NOTE_SI    = 4'd7;
    localparam logic [3:0] NOTE_HI_DO = 4'd8;

    // Tone frequencies in Hz for codes NOTE_DO..NOTE_HI_DO, in order.
    localparam int NOTE_FREQ_HZ [8] = '{523, 587, 659, 698, 784, 880, 988, 1047};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NOTE = 2'd1,
        ST_REST = 2'd2
    } state_t;

    // Half tone period in clk cycles, truncated; 0 means mute (codes 0 and 9..15).
    function automatic logic [HALF_W-1:0] half_period(input int host_hz, input logic [3:0] code);
        if (code >= NOTE_DO && code <= NOTE_HI_DO)
            return HALF_W'(host_hz / (2 * NOTE_FREQ_HZ[3'(code - NOTE_DO)]));
        return '0;
    endfunction

    // A programmed length of zero ticks plays as one tick.
    function automatic logic [7:0] len_ticks(input logic [7:0] len);
        return (len == 8'd0) ? 8'd1 : len;
    endfunction

endpackage

// File: rtl/melody_tone_gen.sv
// Square-wave tone generator: toggles tone_o every `half` clk cycles, held low when half is 0.
// Latency: restart clears the counter at the next edge; first rise `half` cycles after that.
// Backpressure: none; free-running whenever restart is low.
module melody_tone_gen
    import melody_buzzer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic [HALF_W-1:0] half,
    output logic              tone_o
);

    logic [HALF_W-1:0] cnt;

    // Half-period counter; restart or a mute code parks the output low with the counter at zero.
    always_ff @(posedge clk) begin
        if (rst || restart || half == '0) begin
            cnt    <= '0;
            tone_o <= 1'b0;
        end else if (cnt == half - HALF_W'(1)) begin
            cnt    <= '0;
            tone_o <= ~tone_o;
        end else begin
            cnt <= cnt + HALF_W'(1);
        end
    end

endmodule

// File: rtl/melody_buzzer.sv
// Melody player: steps through a note table with programmable note/rest lengths, one-shot or looped.
// Latency: busy_o and the first note one cycle after start_i; outputs idle one cycle after stop_i/rst.
// Backpressure: none; start_i is dropped while busy or when stop_i is coincident.
module melody_buzzer
    import melody_buzzer_pkg::*;
#(
    parameter  int HOST_HZ = 100_000_000,
    parameter  int SEQ_LEN = 8,
    parameter  int TICK_HZ = 1000,
    localparam int AW      = $clog2(SEQ_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          stop_i,
    input  logic          loop_i,
    input  logic [7:0]    note_len_i,
    input  logic [7:0]    rest_len_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [3:0]    wr_note_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [AW-1:0] note_idx_o,
    output logic          buzzer_out_o
);

    localparam int TICK_DIV = HOST_HZ / TICK_HZ;
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [3:0]        note_tbl [SEQ_LEN];
    state_t            state;
    logic [AW-1:0]     idx;
    logic [3:0]        cur_code;
    logic              loop_r;
    logic [7:0]        note_len_r;
    logic [7:0]        rest_len_r;
    logic [7:0]        dur_cnt;
    logic [PW-1:0]     presc;
    logic [HALF_W-1:0] half;

    logic              tick;
    logic              phase_end;
    logic              last_idx;
    logic              has_rest;
    logic              advance;
    logic              start_ok;
    logic              enter_note;
    logic              tone_restart;
    logic [AW-1:0]     next_idx;

    assign tick       = (presc == PW'(TICK_DIV - 1));
    assign phase_end  = (state != ST_IDLE) && tick && (dur_cnt == 8'd1);
    assign last_idx   = (idx == AW'(SEQ_LEN - 1));
    assign has_rest   = (rest_len_r != 8'd0);
    assign advance    = phase_end && ((state == ST_REST) || !has_rest);
    assign start_ok   = (state == ST_IDLE) && start_i && !stop_i;
    assign enter_note = start_ok || (advance && !stop_i && (!last_idx || loop_r));
    assign next_idx   = last_idx ? '0 : idx + 1'b1;
    // Clearing on every NOTE entry makes each note start low; outside NOTE the tone stays parked.
    assign tone_restart = (state != ST_NOTE) || phase_end || stop_i || enter_note;
    assign note_idx_o   = idx;

    // Note table: cleared on reset, writable at any time; out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SEQ_LEN; i++)
                note_tbl[i] <= NOTE_MUTE;
        end else if (wr_en_i && (int'(wr_addr_i) < SEQ_LEN)) begin
            note_tbl[wr_addr_i] <= wr_note_i;
        end
    end

    // Half period of the latched note; each loop iteration folds to a constant.
    always_comb begin
        half = '0;
        for (int c = 0; c < 16; c++)
            if (cur_code == 4'(c))
                half = half_period(HOST_HZ, 4'(c));
    end

    // Playback FSM with the duration prescaler and tick counter; all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            idx        <= '0;
            cur_code   <= NOTE_MUTE;
            loop_r     <= 1'b0;
            note_len_r <= 8'd0;
            rest_len_r <= 8'd0;
            dur_cnt    <= 8'd0;
            presc      <= '0;
        end else begin
            done_o <= 1'b0;
            presc  <= (state == ST_IDLE || tick) ? '0 : presc + 1'b1;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        state      <= ST_NOTE;
                        busy_o     <= 1'b1;
                        loop_r     <= loop_i;
                        note_len_r <= note_len_i;
                        rest_len_r <= rest_len_i;
                        dur_cnt    <= len_ticks(note_len_i);
                        idx        <= '0;
                        cur_code   <= note_tbl[0];
                    end
                end
                ST_NOTE, ST_REST: begin
                    if (stop_i) begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end else if (phase_end) begin
                        if (state == ST_NOTE && has_rest) begin
                            state   <= ST_REST;
                            dur_cnt <= len_ticks(rest_len_r);
                        end else if (enter_note) begin
                            state    <= ST_NOTE;
                            idx      <= next_idx;
                            cur_code <= note_tbl[next_idx];
                            dur_cnt  <= len_ticks(note_len_r);
                        end else begin
                            state  <= ST_IDLE;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end
                    end else if (tick) begin
                        dur_cnt <= dur_cnt - 8'd1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    melody_tone_gen u_tone (
        .clk     (clk),
        .rst     (rst),
        .restart (tone_restart),
        .half    (half),
        .tone_o  (buzzer_out_o)
    );

endmodule

// File: tb/tb_melody_buzzer.sv
// Self-checking bench for melody_buzzer: per-note scoreboard of tone timing plus directed control checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_melody_buzzer;

    localparam int SEQ_LEN = 4;
    localparam int AW      = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic          stop_i;
    logic          loop_i;
    logic [7:0]    note_len_i;
    logic [7:0]    rest_len_i;
    logic          wr_en_i;
    logic [AW-1:0] wr_addr_i;
    logic [3:0]    wr_note_i;
    logic          busy_o;
    logic          done_o;
    logic [AW-1:0] note_idx_o;
    logic          buzzer_out_o;

    always #5 clk = ~clk;

    melody_buzzer #(
        .HOST_HZ (1_000_000),
        .SEQ_LEN (SEQ_LEN),
        .TICK_HZ (1000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .loop_i       (loop_i),
        .note_len_i   (note_len_i),
        .rest_len_i   (rest_len_i),
        .wr_en_i      (wr_en_i),
        .wr_addr_i    (wr_addr_i),
        .wr_note_i    (wr_note_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .note_idx_o   (note_idx_o),
        .buzzer_out_o (buzzer_out_o)
    );

    // One expected record per played note: index, first rise/fall offsets from
    // note entry (-1 if none), total cycles until the next note, note-phase cycles.
    typedef struct {
        int idx;
        int rise;
        int fall;
        int len;
        int note_cyc;
    } note_rec_t;

    note_rec_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic note_rec_t mk(input int idx, input int half, input int note_cyc, input int len);
        note_rec_t r;
        r.idx      = idx;
        r.note_cyc = note_cyc;
        r.len      = len;
        r.rise     = (half > 0 && half < note_cyc) ? half : -1;
        r.fall     = (half > 0 && 2 * half < note_cyc) ? 2 * half : -1;
        return r;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    bit            rec_open = 1'b0;
    bit            discard  = 1'b0;
    int            n, rise_at, fall_at, last_hi, rec_idx;
    logic [AW-1:0] idx_q    = '0;
    int            done_cnt = 0;
    int            done_cyc = -1;
    logic          done_busy;

    task automatic close_rec();
        note_rec_t e;
        chk("rec_expected_pending", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rec_idx", rec_idx, e.idx);
            chk("rec_first_rise", rise_at, e.rise);
            chk("rec_first_fall", fall_at, e.fall);
            chk("rec_note_len", n, e.len);
            chk("rec_low_after_note", int'(last_hi < e.note_cyc), 1);
        end
    endtask

    always @(negedge clk) begin
        if (done_o === 1'b1) begin
            done_cnt++;
            done_cyc  = cyc;
            done_busy = busy_o;
        end
        if (rec_open && (busy_o !== 1'b1 || note_idx_o != idx_q)) begin
            if (busy_o !== 1'b1 && discard) discard = 1'b0;
            else close_rec();
            rec_open = 1'b0;
        end
        if (busy_o === 1'b1 && !rec_open) begin
            rec_open = 1'b1;
            n        = 0;
            rise_at  = -1;
            fall_at  = -1;
            last_hi  = -1;
            rec_idx  = int'(note_idx_o);
        end
        if (rec_open) begin
            if (buzzer_out_o === 1'b1) begin
                if (rise_at < 0) rise_at = n;
                last_hi = n;
            end else if (rise_at >= 0 && fall_at < 0) begin
                fall_at = n;
            end
            n++;
        end
        idx_q = note_idx_o;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int code);
        wr_en_i   = 1'b1;
        wr_addr_i = AW'(a);
        wr_note_i = 4'(code);
        step(1);
        wr_en_i   = 1'b0;
    endtask

    task automatic start(input bit lp, input int nl, input int rl, output int t0);
        loop_i     = lp;
        note_len_i = 8'(nl);
        rest_len_i = 8'(rl);
        start_i    = 1'b1;
        t0         = cyc;
        step(1);
        start_i    = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        while (busy_o === 1'b1 && k < budget) begin
            step(1);
            k++;
        end
        chk({tag, "_idle_within_budget"}, int'(busy_o === 1'b0), 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int t0;
        rst        = 1'b1;
        start_i    = 1'b0;
        stop_i     = 1'b0;
        loop_i     = 1'b0;
        note_len_i = 8'd0;
        rest_len_i = 8'd0;
        wr_en_i    = 1'b0;
        wr_addr_i  = '0;
        wr_note_i  = 4'd0;
        step(3);
        rst = 1'b0;
        step(1);

        chk("reset_busy", int'(busy_o), 0);
        chk("reset_done", int'(done_o), 0);
        chk("reset_idx", int'(note_idx_o), 0);
        chk("reset_buzzer", int'(buzzer_out_o), 0);

        // Scale one-shot with rests, plus a start request while busy.
        wr(0, 1); wr(1, 2); wr(2, 3); wr(3, 8);
        exp_q.push_back(mk(0, 956, 2000, 3000));
        exp_q.push_back(mk(1, 851, 2000, 3000));
        exp_q.push_back(mk(2, 758, 2000, 3000));
        exp_q.push_back(mk(3, 477, 2000, 3000));
        done_cnt = 0;
        start(1'b0, 2, 1, t0);
        chk("scale_busy_after_start", int'(busy_o), 1);
        step(500);
        loop_i     = 1'b1;
        note_len_i = 8'd9;
        start_i    = 1'b1;
        step(1);
        start_i    = 1'b0;
        loop_i     = 1'b0;
        chk("busy_start_ignored_idx", int'(note_idx_o), 0);
        wait_idle(13000, "scale");
        step(2);
        chk("scale_done_count", done_cnt, 1);
        chk("scale_done_cycle", done_cyc - t0, 12001);
        chk("scale_busy_low_with_done", int'(done_busy), 0);
        chk("scale_queue_drained", exp_q.size(), 0);

        // Start and stop together while idle: start must be dropped.
        start_i = 1'b1;
        stop_i  = 1'b1;
        step(1);
        start_i = 1'b0;
        stop_i  = 1'b0;
        chk("start_stop_idle_busy", int'(busy_o), 0);

        // Looped playback with a live write to the playing index, then stop.
        exp_q.push_back(mk(0, 956, 2000, 2000));
        exp_q.push_back(mk(1, 851, 2000, 2000));
        exp_q.push_back(mk(2, 758, 2000, 2000));
        exp_q.push_back(mk(3, 477, 2000, 2000));
        exp_q.push_back(mk(0, 956, 2000, 2000));
        exp_q.push_back(mk(1, 637, 2000, 2000));
        exp_q.push_back(mk(2, 758, 2000, 2000));
        exp_q.push_back(mk(3, 477, 2000, 2000));
        exp_q.push_back(mk(0, 956, 2000, 2000));
        exp_q.push_back(mk(1, 637, 2000, 2000));
        done_cnt = 0;
        start(1'b1, 2, 0, t0);
        step(2499);
        chk("live_idx_at_write", int'(note_idx_o), 1);
        wr(1, 5);
        step(18499);
        chk("loop_idx_before_stop", int'(note_idx_o), 2);
        chk("loop_buzzer_high_before_stop", int'(buzzer_out_o), 1);
        discard = 1'b1;
        stop_i  = 1'b1;
        step(1);
        stop_i  = 1'b0;
        chk("stop_busy_next_cycle", int'(busy_o), 0);
        chk("stop_buzzer_next_cycle", int'(buzzer_out_o), 0);
        step(3);
        chk("loop_no_done", done_cnt, 0);
        chk("loop_queue_drained", exp_q.size(), 0);

        // Mute codes and zero lengths.
        wr(0, 0); wr(1, 12); wr(2, 1); wr(3, 0);
        exp_q.push_back(mk(0, 0, 1000, 1000));
        exp_q.push_back(mk(1, 0, 1000, 1000));
        exp_q.push_back(mk(2, 956, 1000, 1000));
        exp_q.push_back(mk(3, 0, 1000, 1000));
        done_cnt = 0;
        start(1'b0, 0, 0, t0);
        wait_idle(5000, "mute");
        step(2);
        chk("mute_done_count", done_cnt, 1);
        chk("mute_done_cycle", done_cyc - t0, 4001);
        chk("mute_queue_drained", exp_q.size(), 0);

        // Reset in the middle of a sounding note.
        wr(0, 3); wr(1, 3); wr(2, 3); wr(3, 3);
        exp_q.push_back(mk(0, 758, 1000, 1000));
        start(1'b0, 1, 0, t0);
        step(1799);
        chk("prerst_idx", int'(note_idx_o), 1);
        chk("prerst_buzzer_high", int'(buzzer_out_o), 1);
        discard = 1'b1;
        rst     = 1'b1;
        step(1);
        rst     = 1'b0;
        chk("midrst_busy", int'(busy_o), 0);
        chk("midrst_done", int'(done_o), 0);
        chk("midrst_idx", int'(note_idx_o), 0);
        chk("midrst_buzzer", int'(buzzer_out_o), 0);

        // Table must read back as all mute after the reset.
        exp_q.push_back(mk(0, 0, 1000, 1000));
        exp_q.push_back(mk(1, 0, 1000, 1000));
        exp_q.push_back(mk(2, 0, 1000, 1000));
        exp_q.push_back(mk(3, 0, 1000, 1000));
        done_cnt = 0;
        start(1'b0, 0, 0, t0);
        wait_idle(5000, "postrst");
        step(2);
        chk("postrst_done_count", done_cnt, 1);
        chk("postrst_queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
